// File: rtl/seg_mux_driver_if.sv
// Pattern/control inputs and pin-side outputs of the multiplexed 7-segment driver.
interface seg_mux_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int SEG_W      = 8,
  parameter int BRIGHT_W   = 4
);
  logic                        i_enable;
  logic [NUM_DIGITS*SEG_W-1:0] i_segs;
  logic [NUM_DIGITS-1:0]       i_digit_en;
  logic [BRIGHT_W-1:0]         i_brightness;
  logic [SEG_W-1:0]            o_segments;
  logic [NUM_DIGITS-1:0]       o_digits;
  logic                        o_frame_start;

  modport master (
    output i_enable, i_segs, i_digit_en, i_brightness,
    input  o_segments, o_digits, o_frame_start
  );

  modport slave (
    input  i_enable, i_segs, i_digit_en, i_brightness,
    output o_segments, o_digits, o_frame_start
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Time-multiplexed 7-segment scanner with blanking, per-digit enable, PWM and frame strobe.
// Latency: outputs registered, one cycle after internal state; backpressure: none, free-running scan.
module seg_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SEG_W        = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BRIGHT_W     = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic              i_sclk,
  input logic              i_reset,
  seg_mux_driver_if.slave  bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [BRIGHT_W-1:0]   phase, phase_nxt;
  logic [SEG_W-1:0]      seg_lat;
  logic                  en_lat;
  logic [BRIGHT_W-1:0]   bright_lat;

  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] dig_q;
  logic                  frame_q;

  logic                  slot_start;
  logic                  pwm_on;
  logic                  lit;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic [SEG_W-1:0]      seg_cur;

  always_comb begin
    slot_start = (div_cnt == '0);
    pwm_on     = (bright_lat == '1) || (phase < bright_lat);
    lit        = bus.i_enable && en_lat && pwm_on && (div_cnt >= BLANK_END);
    seg_cur    = bus.i_segs[int'(idx)*SEG_W +: SEG_W];

    dig_sel      = '0;
    dig_sel[idx] = 1'b1;

    div_nxt   = div_cnt + 1'b1;
    idx_nxt   = idx;
    phase_nxt = phase + 1'b1;
    if (div_cnt == DIV_LAST) begin
      div_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    // Disabled scan parks at digit 0 so re-enable starts a fresh frame.
    if (!bus.i_enable) begin
      div_nxt   = '0;
      idx_nxt   = '0;
      phase_nxt = '0;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      div_cnt    <= '0;
      idx        <= '0;
      phase      <= '0;
      seg_lat    <= '0;
      en_lat     <= 1'b0;
      bright_lat <= '0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
      frame_q    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      idx     <= idx_nxt;
      phase   <= phase_nxt;
      // Slot snapshot: later input changes wait for this digit's next slot.
      if (slot_start) begin
        seg_lat    <= seg_cur;
        en_lat     <= bus.i_digit_en[idx];
        bright_lat <= bus.i_brightness;
      end
      if (lit) begin
        seg_q <= ACTIVE_LOW ? ~seg_lat : seg_lat;
        dig_q <= ACTIVE_LOW ? ~dig_sel : dig_sel;
      end else begin
        seg_q <= SEG_OFF;
        dig_q <= DIG_OFF;
      end
      frame_q <= bus.i_enable && slot_start && (idx == '0);
    end
  end

  assign bus.o_segments    = seg_q;
  assign bus.o_digits      = dig_q;
  assign bus.o_frame_start = frame_q;

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Parametrised time-multiplexed driver for a common-anode/cathode 7-segment array. It is the successor to the fixed six-digit adapter. It scans NUM_DIGITS digit patterns onto a shared segment bus and adds the following:
- Programmable refresh rate.
- Anti-ghosting blanking.
- Per-digit enable.
- PWM brightness.
- Frame-start strobe.

It sits between the stopwatch/RTC digit encoders and the board pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
SEG_W, 8, segment bits per digit (7 segments + DP)
REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 4, cycles at start of each slot with all digits off
BRIGHT_W, 4, brightness control width
ACTIVE_LOW, 1, 1 = segment and digit outputs active-low (Nexys A7); 0 = active-high

Ports:
i_sclk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_enable  in  1  scan enable; 0 blanks display and holds scan at digit 0
i_segs  in  NUM_DIGITS*SEG_W  digit k pattern at [k*SEG_W +: SEG_W], 1 = segment lit
i_digit_en  in  NUM_DIGITS  per-digit enable, 1 = digit may light
i_brightness  in  BRIGHT_W  duty level; 0 = off, all-ones = full on
o_segments  out  SEG_W  segment drive, polarity per ACTIVE_LOW
o_digits  out  NUM_DIGITS  digit select, one-hot when lit, polarity per ACTIVE_LOW
o_frame_start  out  1  one-cycle pulse at start of digit-0 slot

Behaviour:
- Clock and reset: single clock i_sclk. i_reset is synchronous and active-high.
- Reset values:
  - All outputs inactive: o_segments = all ones if ACTIVE_LOW, else all zeros. o_digits likewise.
  - o_frame_start = 0.
  - Internal registers: slot counter div_cnt = 0, digit index idx = 0, PWM phase = 0, latched pattern/brightness = 0.
- Scan:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0 and advances idx.
  - idx wraps from NUM_DIGITS-1 to 0.
  - Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- Snapshot:
  - In the cycle div_cnt==0, capture i_segs slice idx, i_digit_en[idx] and i_brightness into slot registers.
  - Input changes mid-slot have no effect until that digit's next slot (no tearing).
- PWM:
  - Free-running BRIGHT_W-bit phase counter, +1 every enabled cycle, wraps.
  - pwm_on = (bright_lat == all ones) || (phase < bright_lat).
- Lit condition: lit = i_enable && en_lat && pwm_on && (div_cnt >= BLANK_CYCLES).
- Outputs (all registered, one-cycle latency from internal state):
  - When lit: o_digits drives only bit idx active, and o_segments = seg_lat, polarity applied.
  - Otherwise: both buses inactive.
  - Segments are never driven active while o_digits is inactive.
- Frame strobe:
  - o_frame_start = 1 for exactly one cycle, registered from (i_enable && div_cnt==0 && idx==0).
  - Pulses every frame, independent of digit enables and brightness.
- Disabled digit: slot still consumed (fixed frame timing) and both buses stay inactive for that slot.
- i_enable = 0:
  - div_cnt, idx and phase are forced to 0 and outputs go inactive on the next cycle.
  - On re-enable, scanning restarts at digit 0 with div_cnt = 0 and a frame_start pulse.
- Reset mid-slot: takes effect on the next edge regardless of state. Same restart as re-enable once i_reset deasserts.
- NUM_DIGITS = 1: idx is constant 0, and frame_start pulses every REFRESH_DIV cycles.
- Widths:
  - div_cnt width = clog2(REFRESH_DIV).
  - idx width = max(1, clog2(NUM_DIGITS)).
  - Comparisons are unsigned, with no truncation of REFRESH_DIV-1.

Test Plan:
Bench config: NUM_DIGITS=6, SEG_W=8, REFRESH_DIV=8, BLANK_CYCLES=2, BRIGHT_W=2, ACTIVE_LOW=1.
1. Reset: hold i_reset 3 cycles with i_enable=1 -> o_segments=8'hFF, o_digits=6'h3F, o_frame_start=0 throughout.
2. Scan order: digit k = 8'h11*(k+1), i_digit_en=6'h3F, i_brightness=3 ->
   - Each 8-cycle slot: 2 blank cycles, then 6 cycles with o_digits bit k low (digit 0 = 6'h3E) and o_segments = ~(8'h11*(k+1)).
   - o_frame_start pulses every 48 cycles.
3. Brightness:
   - i_brightness=1 -> in non-blank cycles, digit lit only when phase==0 (1 in 4 cycles).
   - i_brightness=0 -> o_digits stays 6'h3F, o_segments stays 8'hFF, frame_start still pulses.
4. Digit disable: i_digit_en=6'b111011 -> slot 2 fully inactive, slots 1 and 3 start at unchanged cycle positions.
5. Snapshot: change digit 1 from 8'h22 to 8'h7E at div_cnt=4 of slot 1 -> rest of slot shows ~8'h22; next frame's slot 1 shows ~8'h7E.
6. Reset/enable mid-operation:
   - Assert i_reset (or drop i_enable) during slot 3 -> next cycle all outputs inactive.
   - After release -> o_frame_start pulses, then digit 0 lights at cycle BLANK_CYCLES+1 after release.
